// File: rtl/fpu_cvt_arb_queue_pkg.sv
// rtl/fpu_cvt_arb_queue_pkg.sv - fop codes and convert-mode decode shared by the convert front end
//
// Purpose: operation codes for the FP->int convert path, the legality test applied at the lane
// inputs and the mode decode applied to the op presented to the convert unit.
// Ports: none (package).

package fpu_cvt_arb_queue_pkg;

    localparam logic [7:0] FOP_CVT_D   = 8'h20;
    localparam logic [7:0] FOP_CVT_E   = 8'h21;
    localparam logic [7:0] FOP_CVT_S   = 8'h22;
    localparam logic [7:0] FOP_CVT32_S = 8'h23;
    localparam logic [7:0] FOP_CVT32_D = 8'h24;
    localparam logic [7:0] FOP_TBL_D   = 8'h25;

    typedef struct packed {
        logic is_dbl;
        logic is_ext;
        logic is_sng;
        logic verbatim;
        logic is_32b;
    } cvt_mode_t;

    function automatic logic fop_is_cvt(input logic [7:0] op);
        case (op)
            FOP_CVT_D, FOP_CVT_E, FOP_CVT_S,
            FOP_CVT32_S, FOP_CVT32_D, FOP_TBL_D: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    // Single precision is the fallback mode: anything that is not a double or extended source.
    function automatic cvt_mode_t fop_decode(input logic [7:0] op);
        cvt_mode_t m;
        logic      d;
        logic      e;
        d          = (op == FOP_CVT_D) || (op == FOP_CVT32_D);
        e          = (op == FOP_CVT_E);
        m.is_dbl   = d;
        m.is_ext   = e;
        m.is_sng   = ~(d | e);
        m.verbatim = (op == FOP_TBL_D);
        m.is_32b   = (op == FOP_CVT32_S) || (op == FOP_CVT32_D);
        return m;
    endfunction

endpackage

// File: rtl/fpu_cvt_lane_fifo.sv
// rtl/fpu_cvt_lane_fifo.sv - per-lane request FIFO feeding the convert arbiter
//
// Purpose: DEPTH-entry queue of packed {op,data,tag} words for one lane.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   push_i, wdata_i   write request and word (ignored when full)
//   pop_i             read request (ignored when empty)
//   rdata_o           word at the head
//   rdy_o             not full, from registered count
//   nempty_o          not empty, from registered count

module fpu_cvt_lane_fifo
    import fpu_cvt_arb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         rdy_o,
    output logic         nempty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          push_ok;
    logic          pop_ok;

    assign rdy_o    = (count_q != CW'(DEPTH));
    assign nempty_o = (count_q != '0);
    assign push_ok  = push_i & rdy_o;
    assign pop_ok   = pop_i & nempty_o;
    assign rdata_o  = mem_q[rd_ptr_q];

    // Simultaneous push and pop leaves the count unchanged while both pointers move.
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fpu_cvt_arb_queue.sv
// rtl/fpu_cvt_arb_queue.sv - shared FP->int convert front end with per-lane queues and RR issue
//
// Purpose: each lane queues convert requests; a round-robin arbiter issues one per enabled cycle
// through two register stages to the convert unit and tracks the result owner through a
// fixed-latency return line. Pipeline state only advances while clk_en_i is high; lane pushes
// are accepted regardless of clk_en_i.
// Ports:
//   clk_i, rst_i, clk_en_i            clock, sync active-high reset, pipeline advance enable
//   in_vld_i/in_op_i/in_data_i/in_tag_i  per-lane request (flattened, lane 0 in the LSBs)
//   in_rdy_o                          per-lane FIFO not full
//   cvt_vld_o, cvt_data_o, cvt_is*_o  request and decoded mode at the convert unit
//   ret_vld_o, ret_lane_o, ret_tag_o  result owner, due this cycle
//   ovf_err_o, op_err_o               sticky per-lane drop flags (full / illegal op)

module fpu_cvt_arb_queue
    import fpu_cvt_arb_queue_pkg::*;
#(
    parameter int LANES = 3,
    parameter int DEPTH = 4,
    parameter int DW    = 84,
    parameter int TAGW  = 9,
    parameter int LAT   = 3,
    localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clk_en_i,
    input  logic [LANES-1:0]      in_vld_i,
    input  logic [LANES*8-1:0]    in_op_i,
    input  logic [LANES*DW-1:0]   in_data_i,
    input  logic [LANES*TAGW-1:0] in_tag_i,
    output logic [LANES-1:0]      in_rdy_o,
    output logic                  cvt_vld_o,
    output logic [DW-1:0]         cvt_data_o,
    output logic                  cvt_isDBL_o,
    output logic                  cvt_isEXT_o,
    output logic                  cvt_isSNG_o,
    output logic                  cvt_verbatim_o,
    output logic                  cvt_is32b_o,
    output logic                  ret_vld_o,
    output logic [LW-1:0]         ret_lane_o,
    output logic [TAGW-1:0]       ret_tag_o,
    output logic [LANES-1:0]      ovf_err_o,
    output logic [LANES-1:0]      op_err_o
);

    localparam int RW = 8 + DW + TAGW;

    logic [LANES-1:0] legal;
    logic [LANES-1:0] push;
    logic [LANES-1:0] pop;
    logic [LANES-1:0] nempty;
    logic [RW-1:0]    rdata [LANES];

    logic             win_vld;
    logic [LW-1:0]    win;
    logic             pop_en;
    logic [LW-1:0]    rr_q;
    logic [LW-1:0]    rr_d;
    logic [RW-1:0]    head;

    logic             s1_vld_q;
    logic [LW-1:0]    s1_lane_q;
    logic [7:0]       s1_op_q;
    logic [DW-1:0]    s1_data_q;
    logic [TAGW-1:0]  s1_tag_q;
    logic             s2_vld_q;
    logic [LW-1:0]    s2_lane_q;
    logic [7:0]       s2_op_q;
    logic [DW-1:0]    s2_data_q;
    logic [TAGW-1:0]  s2_tag_q;

    logic             rl_vld_q  [LAT];
    logic [LW-1:0]    rl_lane_q [LAT];
    logic [TAGW-1:0]  rl_tag_q  [LAT];

    cvt_mode_t        mode;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign legal[l] = fop_is_cvt(in_op_i[l*8 +: 8]);
        assign push[l]  = in_vld_i[l] & in_rdy_o[l] & legal[l];
        assign pop[l]   = pop_en && (win == LW'(l));

        fpu_cvt_lane_fifo #(
            .DEPTH (DEPTH),
            .W     (RW)
        ) u_fifo (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .push_i   (push[l]),
            .pop_i    (pop[l]),
            .wdata_i  ({in_op_i[l*8 +: 8], in_data_i[l*DW +: DW], in_tag_i[l*TAGW +: TAGW]}),
            .rdata_o  (rdata[l]),
            .rdy_o    (in_rdy_o[l]),
            .nempty_o (nempty[l])
        );
    end

    // First non-empty lane at or after the rr pointer, wrapping. Candidates use registered
    // counts, so an entry pushed this cycle is not visible until the next edge.
    always_comb begin
        win_vld = 1'b0;
        win     = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!win_vld && nempty[(int'(rr_q) + i) % LANES]) begin
                win_vld = 1'b1;
                win     = LW'((int'(rr_q) + i) % LANES);
            end
        end
    end

    assign pop_en = clk_en_i & win_vld;
    assign rr_d   = (win == LW'(LANES - 1)) ? '0 : win + LW'(1);
    assign head   = rdata[win];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q      <= '0;
            s1_vld_q  <= 1'b0;
            s1_lane_q <= '0;
            s1_op_q   <= '0;
            s1_data_q <= '0;
            s1_tag_q  <= '0;
            s2_vld_q  <= 1'b0;
            s2_lane_q <= '0;
            s2_op_q   <= '0;
            s2_data_q <= '0;
            s2_tag_q  <= '0;
        end else if (clk_en_i) begin
            if (pop_en) rr_q <= rr_d;
            s1_vld_q <= pop_en;
            if (pop_en) begin
                s1_lane_q <= win;
                {s1_op_q, s1_data_q, s1_tag_q} <= head;
            end
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_lane_q <= s1_lane_q;
                s2_op_q   <= s1_op_q;
                s2_data_q <= s1_data_q;
                s2_tag_q  <= s1_tag_q;
            end
        end
    end

    // Return line mirrors the convert unit latency; it freezes together with the unit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < LAT; i++) begin
                rl_vld_q[i]  <= 1'b0;
                rl_lane_q[i] <= '0;
                rl_tag_q[i]  <= '0;
            end
        end else if (clk_en_i) begin
            rl_vld_q[0]  <= s2_vld_q;
            rl_lane_q[0] <= s2_lane_q;
            rl_tag_q[0]  <= s2_tag_q;
            for (int i = 1; i < LAT; i++) begin
                rl_vld_q[i]  <= rl_vld_q[i-1];
                rl_lane_q[i] <= rl_lane_q[i-1];
                rl_tag_q[i]  <= rl_tag_q[i-1];
            end
        end
    end

    // Drop flags follow the push side, so they are not gated by clk_en_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_err_o <= '0;
            op_err_o  <= '0;
        end else begin
            ovf_err_o <= ovf_err_o | (in_vld_i & legal & ~in_rdy_o);
            op_err_o  <= op_err_o | (in_vld_i & ~legal);
        end
    end

    // Mode bits are qualified by valid so an idle unit sees all zeros.
    assign mode           = s2_vld_q ? fop_decode(s2_op_q) : '0;
    assign cvt_vld_o      = s2_vld_q;
    assign cvt_data_o     = s2_data_q;
    assign cvt_isDBL_o    = mode.is_dbl;
    assign cvt_isEXT_o    = mode.is_ext;
    assign cvt_isSNG_o    = mode.is_sng;
    assign cvt_verbatim_o = mode.verbatim;
    assign cvt_is32b_o    = mode.is_32b;

    assign ret_vld_o  = rl_vld_q[LAT-1];
    assign ret_lane_o = rl_lane_q[LAT-1];
    assign ret_tag_o  = rl_tag_q[LAT-1];

endmodule

// File: tb/tb_fpu_cvt_arb_queue.sv
// tb/tb_fpu_cvt_arb_queue.sv - self-checking bench for fpu_cvt_arb_queue

module tb_fpu_cvt_arb_queue;
    import fpu_cvt_arb_queue_pkg::*;

    localparam int LANES = 3;
    localparam int DEPTH = 4;
    localparam int DW    = 84;
    localparam int TAGW  = 9;
    localparam int LAT   = 3;
    localparam int LW    = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  clk_en;
    logic [LANES-1:0]      in_vld;
    logic [LANES*8-1:0]    in_op;
    logic [LANES*DW-1:0]   in_data;
    logic [LANES*TAGW-1:0] in_tag;
    logic [LANES-1:0]      in_rdy;
    logic                  cvt_vld;
    logic [DW-1:0]         cvt_data;
    logic                  is_dbl, is_ext, is_sng, verbatim, is_32b;
    logic                  ret_vld;
    logic [LW-1:0]         ret_lane;
    logic [TAGW-1:0]       ret_tag;
    logic [LANES-1:0]      ovf_err;
    logic [LANES-1:0]      op_err;

    always #5 clk = ~clk;

    fpu_cvt_arb_queue #(
        .LANES (LANES), .DEPTH (DEPTH), .DW (DW), .TAGW (TAGW), .LAT (LAT)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .clk_en_i       (clk_en),
        .in_vld_i       (in_vld),
        .in_op_i        (in_op),
        .in_data_i      (in_data),
        .in_tag_i       (in_tag),
        .in_rdy_o       (in_rdy),
        .cvt_vld_o      (cvt_vld),
        .cvt_data_o     (cvt_data),
        .cvt_isDBL_o    (is_dbl),
        .cvt_isEXT_o    (is_ext),
        .cvt_isSNG_o    (is_sng),
        .cvt_verbatim_o (verbatim),
        .cvt_is32b_o    (is_32b),
        .ret_vld_o      (ret_vld),
        .ret_lane_o     (ret_lane),
        .ret_tag_o      (ret_tag),
        .ovf_err_o      (ovf_err),
        .op_err_o       (op_err)
    );

    typedef struct {
        int         lane;
        logic [7:0] op;
        int         tag;
        logic [4:0] mode;   // {dbl, ext, sng, verbatim, 32b}
    } vec_t;

    vec_t vecs [6];

    int n_chk  = 0;
    int n_fail = 0;

    bit mon_on = 1'b0;
    int ci, ri, n_exp;
    int exp_lane [32];
    int exp_tag  [32];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mkdata(input int lane, input int tag);
        return {12'hC3A, 56'h0123_4567_89AB_CD, 4'(lane), 12'(tag)};
    endfunction

    // Stream checker: a new cvt/ret item appears only after an enabled edge.
    task automatic monitor_step();
        if (cvt_vld) begin
            chk("cvt_stream_len", 128'(ci < n_exp), 128'(1));
            if (ci < n_exp) chk("cvt_stream_data", cvt_data, mkdata(exp_lane[ci], exp_tag[ci]));
            ci++;
        end
        if (ret_vld) begin
            chk("ret_stream_len", 128'(ri < n_exp), 128'(1));
            if (ri < n_exp) begin
                chk("ret_stream_lane", ret_lane, exp_lane[ri]);
                chk("ret_stream_tag", ret_tag, exp_tag[ri]);
            end
            ri++;
        end
    endtask

    task automatic tick();
        bit en;
        en = clk_en;
        @(posedge clk);
        #1;
        if (mon_on && en) monitor_step();
    endtask

    task automatic do_reset();
        mon_on = 1'b0;
        rst    = 1'b1;
        clk_en = 1'b1;
        in_vld = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int lane, input logic [7:0] op, input int tag);
        in_op[lane*8 +: 8]         = op;
        in_tag[lane*TAGW +: TAGW]  = TAGW'(tag);
        in_data[lane*DW +: DW]     = mkdata(lane, tag);
        in_vld[lane]               = 1'b1;
    endtask

    task automatic start_mon(input int n);
        ci     = 0;
        ri     = 0;
        n_exp  = n;
        mon_on = 1'b1;
    endtask

    task automatic end_mon(input string name);
        chk({name, "_cvt_count"}, ci, n_exp);
        chk({name, "_ret_count"}, ri, n_exp);
        mon_on = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt;
        bit r;

        vecs[0] = '{1, FOP_CVT_D,   'h005, 5'b10000};
        vecs[1] = '{0, FOP_CVT_E,   'h1FF, 5'b01000};
        vecs[2] = '{2, FOP_CVT_S,   'h100, 5'b00100};
        vecs[3] = '{1, FOP_CVT32_S, 'h0AA, 5'b00101};
        vecs[4] = '{0, FOP_CVT32_D, 'h033, 5'b10001};
        vecs[5] = '{2, FOP_TBL_D,   'h155, 5'b00110};

        in_op   = '0;
        in_data = '0;
        in_tag  = '0;
        do_reset();

        // Reset / idle state
        chk("rst_in_rdy", in_rdy, 3'b111);
        chk("rst_cvt_vld", cvt_vld, 0);
        chk("rst_cvt_data", cvt_data, 0);
        chk("rst_mode", {is_dbl, is_ext, is_sng, verbatim, is_32b}, 0);
        chk("rst_ret_vld", ret_vld, 0);
        chk("rst_ret_lane_tag", {ret_lane, ret_tag}, 0);
        chk("rst_errs", {ovf_err, op_err}, 0);

        // Single-request latency and mode decode per op
        foreach (vecs[i]) begin
            set_req(vecs[i].lane, vecs[i].op, vecs[i].tag);
            tick();                                      // E0: push
            in_vld = '0;
            tick();                                      // E1
            chk("vec_cvt_vld_e1", cvt_vld, 0);
            tick();                                      // E2
            chk("vec_cvt_vld_e2", cvt_vld, 1);
            chk("vec_cvt_data", cvt_data, mkdata(vecs[i].lane, vecs[i].tag));
            chk("vec_mode", {is_dbl, is_ext, is_sng, verbatim, is_32b}, vecs[i].mode);
            tick();
            tick();                                      // E4
            chk("vec_ret_vld_e4", ret_vld, 0);
            tick();                                      // E5
            chk("vec_ret_vld_e5", ret_vld, 1);
            chk("vec_ret_lane", ret_lane, vecs[i].lane);
            chk("vec_ret_tag", ret_tag, vecs[i].tag);
            tick();
        end

        // All lanes push every cycle for 6 cycles: strict 0,1,2 issue, lanes 1/2 overrun
        do_reset();
        for (int i = 0; i < 16; i++) begin
            exp_lane[i] = i % 3;
            exp_tag[i]  = (i % 3) * 16 + i / 3;
        end
        start_mon(16);
        for (int k = 0; k < 6; k++) begin
            for (int l = 0; l < LANES; l++) set_req(l, FOP_CVT_S, l * 16 + k);
            tick();
            if (k == 4) chk("rr_in_rdy_p4", in_rdy, 3'b001);
            if (k == 5) begin
                chk("rr_in_rdy_p5", in_rdy, 3'b010);
                chk("rr_ovf_err", ovf_err, 3'b110);
            end
        end
        in_vld = '0;
        repeat (30) tick();
        end_mon("rr");

        // Freeze mid-stream: outputs hold, pushes still land, order preserved
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exp_lane[i] = 0;
            exp_tag[i]  = i;
        end
        start_mon(8);
        for (int k = 0; k < 4; k++) begin
            set_req(0, FOP_CVT_D, k);
            tick();
        end
        in_vld = '0;
        tick();
        tick();
        chk("frz_pre_cvt_data", cvt_data, mkdata(0, 3));
        chk("frz_pre_ret", {ret_vld, ret_tag}, {1'b1, 9'd0});
        clk_en = 1'b0;
        for (int k = 4; k < 8; k++) begin
            set_req(0, FOP_CVT_D, k);
            tick();
            chk("frz_cvt_vld", cvt_vld, 1);
            chk("frz_cvt_data", cvt_data, mkdata(0, 3));
            chk("frz_ret", {ret_vld, ret_lane, ret_tag}, {1'b1, 2'd0, 9'd0});
        end
        in_vld = '0;
        chk("frz_in_rdy_full", in_rdy, 3'b110);
        clk_en = 1'b1;
        repeat (20) tick();
        end_mon("frz");

        // Illegal op: sticky op_err, queue untouched, reset clears
        do_reset();
        set_req(0, 8'h00, 1);
        tick();
        in_vld = '0;
        chk("op_err_set", op_err, 3'b001);
        chk("op_in_rdy", in_rdy, 3'b111);
        chk("op_no_ovf", ovf_err, 3'b000);
        repeat (3) tick();
        chk("op_no_issue", cvt_vld, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("op_err_clr", op_err, 3'b000);

        // Full lane, overrun while frozen, then push+pop every cycle across pointer wrap
        do_reset();
        for (int i = 0; i < 11; i++) begin
            exp_lane[i] = 0;
            exp_tag[i]  = i;
        end
        start_mon(11);
        clk_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_req(0, FOP_CVT32_D, k);
            tick();
        end
        chk("wrap_full_rdy", in_rdy, 3'b110);
        set_req(0, FOP_CVT32_D, 99);
        tick();
        chk("wrap_ovf", ovf_err, 3'b001);
        clk_en = 1'b1;
        nxt = 4;
        for (int e = 0; e < 8; e++) begin
            r = in_rdy[0];
            set_req(0, FOP_CVT32_D, nxt);
            tick();
            if (r) nxt++;
            chk("wrap_rdy", in_rdy, 3'b111);
        end
        in_vld = '0;
        repeat (20) tick();
        end_mon("wrap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
